multi_bank_buffer: RTL and testbench

//  Parametrised N-bank input buffer: one registered input stream fanned out under a per-word

---
 rtl/multi_bank_buffer_pkg.sv | 18 +
 rtl/multi_bank_buffer_bank_fifo.sv | 73 +++++++
 rtl/multi_bank_buffer.sv | 72 +++++++
 tb/tb_multi_bank_buffer.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/multi_bank_buffer_pkg.sv
// Shared widths, bank limits and helpers for the multi-bank input buffer.
// Revision: 1.0
`default_nettype none

package multi_bank_buffer_pkg;

  localparam int BANK_MAX      = 8;
  localparam int DEF_DATA_W    = 8;
  localparam int DEF_ADDR_W    = 5;
  localparam int DEF_NUM_BANKS = 3;

  function automatic int depth_of(input int addr_w);
    return 1 << addr_w;
  endfunction

endpackage

`default_nettype wire

// File: rtl/multi_bank_buffer_bank_fifo.sv
// One circular bank: DEPTH x DATA_W RAM with registered read, pointers, fill and status.
// Revision: 1.0
`default_nettype none

module bank_fifo
  import multi_bank_buffer_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              pend,
  input  logic              rd_en,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic              empty,
  output logic              full,
  output logic [ADDR_W:0]   fill,
  output logic              underflow
);

  localparam int DEPTH = depth_of(ADDR_W);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic              pop;

  assign pop   = rd_en && (fill != '0);
  assign empty = (fill == '0);
  // The in-flight stage word counts against capacity so an accept never overflows.
  assign full  = (({1'b0, fill} + (ADDR_W+2)'(pend)) == (ADDR_W+2)'(DEPTH));

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      fill      <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      underflow <= 1'b0;
    end else begin
      out_valid <= pop;
      if (pop) begin
        out_data <= mem[rd_ptr];
        rd_ptr   <= rd_ptr + 1'b1;
      end
      if (wr_en) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (rd_en && empty) begin
        underflow <= 1'b1;
      end
      case ({wr_en, pop})
        2'b10:   fill <= fill + 1'b1;
        2'b01:   fill <= fill - 1'b1;
        default: fill <= fill;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: rtl/multi_bank_buffer.sv
// Registered input stage fanned out by word mask into NUM_BANKS independent bank FIFOs.
// Revision: 1.0
`default_nettype none

module multi_bank_buffer
  import multi_bank_buffer_pkg::*;
#(
  parameter int DATA_W    = DEF_DATA_W,
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int NUM_BANKS = DEF_NUM_BANKS
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [DATA_W-1:0]               in_data,
  input  logic [NUM_BANKS-1:0]            in_mask,
  input  logic [NUM_BANKS-1:0]            rd_en,
  output logic [NUM_BANKS-1:0]            out_valid,
  output logic [NUM_BANKS*DATA_W-1:0]     out_data,
  output logic [NUM_BANKS-1:0]            empty,
  output logic [NUM_BANKS-1:0]            full,
  output logic [NUM_BANKS*(ADDR_W+1)-1:0] fill,
  output logic [NUM_BANKS-1:0]            underflow
);

  logic                 pend_valid;
  logic [DATA_W-1:0]    pend_data;
  logic [NUM_BANKS-1:0] pend_mask;
  logic                 accept;

  assign in_ready = !reset && (&(~in_mask | ~full));
  assign accept   = in_valid && in_ready;

  // A zero-mask word still occupies the stage for a cycle and is simply never committed.
  always_ff @(posedge clk) begin
    if (reset) begin
      pend_valid <= 1'b0;
      pend_data  <= '0;
      pend_mask  <= '0;
    end else begin
      pend_valid <= accept;
      if (accept) begin
        pend_data <= in_data;
        pend_mask <= in_mask;
      end
    end
  end

  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
    bank_fifo #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W)
    ) u_bank (
      .clk       (clk),
      .reset     (reset),
      .wr_en     (pend_valid && pend_mask[b]),
      .wr_data   (pend_data),
      .pend      (pend_valid && pend_mask[b]),
      .rd_en     (rd_en[b]),
      .out_valid (out_valid[b]),
      .out_data  (out_data[b*DATA_W +: DATA_W]),
      .empty     (empty[b]),
      .full      (full[b]),
      .fill      (fill[b*(ADDR_W+1) +: (ADDR_W+1)]),
      .underflow (underflow[b])
    );
  end

endmodule

`default_nettype wire

// File: tb/tb_multi_bank_buffer.sv
// Randomized and directed bench for multi_bank_buffer against a queue-based reference model.
`default_nettype none

module tb_multi_bank_buffer;

  localparam int NB    = 3;
  localparam int DW    = 8;
  localparam int AW    = 5;
  localparam int DEPTH = 32;
  localparam int FW    = AW + 1;

  logic                 clk;
  logic                 reset;
  logic                 in_valid;
  logic                 in_ready;
  logic [DW-1:0]        in_data;
  logic [NB-1:0]        in_mask;
  logic [NB-1:0]        rd_en;
  logic [NB-1:0]        out_valid;
  logic [NB*DW-1:0]     out_data;
  logic [NB-1:0]        empty;
  logic [NB-1:0]        full;
  logic [NB*FW-1:0]     fill;
  logic [NB-1:0]        underflow;

  multi_bank_buffer #(.DATA_W(DW), .ADDR_W(AW), .NUM_BANKS(NB)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_mask(in_mask), .rd_en(rd_en), .out_valid(out_valid),
    .out_data(out_data), .empty(empty), .full(full), .fill(fill), .underflow(underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: committed words per bank, one pending stage slot, sticky flags.
  logic [DW-1:0] q [NB][$];
  logic          m_pv;
  logic [DW-1:0] m_pd;
  logic [NB-1:0] m_pm;
  logic [NB-1:0] m_ov;
  logic [NB-1:0] m_uf;
  logic [DW-1:0] m_od [NB];
  logic          obs_ready;
  logic          exp_ready;

  function automatic logic m_full_b(input int b);
    return (q[b].size() + ((m_pv && m_pm[b]) ? 1 : 0)) == DEPTH;
  endfunction

  function automatic logic [NB-1:0] m_empty();
    logic [NB-1:0] r;
    for (int b = 0; b < NB; b++) r[b] = (q[b].size() == 0);
    return r;
  endfunction

  function automatic logic [NB-1:0] m_full();
    logic [NB-1:0] r;
    for (int b = 0; b < NB; b++) r[b] = m_full_b(b);
    return r;
  endfunction

  function automatic logic [NB*FW-1:0] m_fill();
    logic [NB*FW-1:0] r;
    for (int b = 0; b < NB; b++) r[b*FW +: FW] = FW'(q[b].size());
    return r;
  endfunction

  function automatic logic [NB*DW-1:0] m_data();
    logic [NB*DW-1:0] r;
    for (int b = 0; b < NB; b++) r[b*DW +: DW] = m_od[b];
    return r;
  endfunction

  // Drives one cycle from a negedge, advances the model at the posedge, returns at the next negedge.
  task automatic cycle(input logic iv, input logic [DW-1:0] d, input logic [NB-1:0] m,
                       input logic [NB-1:0] rd, input logic rs);
    in_valid = iv; in_data = d; in_mask = m; rd_en = rd; reset = rs;
    #1;
    obs_ready = in_ready;
    exp_ready = !rs;
    for (int b = 0; b < NB; b++) if (m[b] && m_full_b(b)) exp_ready = 1'b0;
    @(posedge clk);
    if (rs) begin
      for (int b = 0; b < NB; b++) begin q[b].delete(); m_od[b] = '0; end
      m_ov = '0; m_uf = '0; m_pv = 1'b0; m_pm = '0; m_pd = '0;
    end else begin
      for (int b = 0; b < NB; b++) begin
        m_ov[b] = 1'b0;
        if (rd[b]) begin
          if (q[b].size() > 0) begin m_od[b] = q[b].pop_front(); m_ov[b] = 1'b1; end
          else m_uf[b] = 1'b1;
        end
      end
      if (m_pv) for (int b = 0; b < NB; b++) if (m_pm[b]) q[b].push_back(m_pd);
      m_pv = iv && exp_ready;
      if (m_pv) begin m_pd = d; m_pm = m; end
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    cycle(0, 0, 0, 0, 1);
    cycle(0, 0, 0, 0, 1);
    checks++; if (obs_ready !== 1'b0) begin errors++; $display("FAIL reset_ready_low: got %b want 0", obs_ready); end
    cycle(0, 0, 0, 0, 0);
    checks++; if (obs_ready !== 1'b1) begin errors++; $display("FAIL idle_ready: got %b want 1", obs_ready); end
    checks++; if (empty !== 3'b111) begin errors++; $display("FAIL reset_empty: got %b want 111", empty); end
    checks++; if (full !== 3'b000) begin errors++; $display("FAIL reset_full: got %b want 000", full); end
    checks++; if (out_valid !== 3'b000) begin errors++; $display("FAIL reset_out_valid: got %b want 000", out_valid); end
    checks++; if (fill !== '0) begin errors++; $display("FAIL reset_fill: got %h want 0", fill); end
    checks++; if (out_data !== '0 || underflow !== '0) begin
      errors++; $display("FAIL reset_data_uf: got data %h uf %b want 0", out_data, underflow); end
  endtask

  task automatic test_single_write();
    cycle(0, 0, 0, 0, 1);
    cycle(1, 8'hA5, 3'b101, 0, 0);
    cycle(0, 0, 0, 0, 0);
    checks++; if (fill !== m_fill() || fill[2*FW +: FW] !== 6'd1) begin
      errors++; $display("FAIL single_commit_fill: got %h want %h", fill, m_fill()); end
    cycle(0, 0, 0, 3'b001, 0);
    checks++; if (out_valid !== 3'b001) begin errors++; $display("FAIL single_pop_valid: got %b want 001", out_valid); end
    checks++; if (out_data[7:0] !== 8'hA5) begin errors++; $display("FAIL single_pop_data: got %h want a5", out_data[7:0]); end
    checks++; if (fill[FW +: FW] !== 6'd0 || fill[2*FW +: FW] !== 6'd1 || fill !== m_fill()) begin
      errors++; $display("FAIL single_fill_after: got %h want %h", fill, m_fill()); end
  endtask

  task automatic test_fill_full();
    cycle(0, 0, 0, 0, 1);
    for (int i = 0; i < DEPTH; i++) begin
      cycle(1, DW'(i), 3'b010, 0, 0);
      checks++; if (obs_ready !== 1'b1 || obs_ready !== exp_ready) begin
        errors++; $display("FAIL fill_ready_%0d: got %b want 1", i, obs_ready); end
    end
    cycle(1, 8'h99, 3'b010, 0, 0);
    checks++; if (obs_ready !== 1'b0 || obs_ready !== exp_ready) begin
      errors++; $display("FAIL full_ready_drop: got %b want 0", obs_ready); end
    cycle(1, 8'h55, 3'b001, 0, 0);
    checks++; if (obs_ready !== 1'b1) begin errors++; $display("FAIL full_other_bank_ready: got %b want 1", obs_ready); end
    cycle(0, 0, 0, 0, 0);
    checks++; if (full[1] !== 1'b1 || full !== m_full()) begin
      errors++; $display("FAIL full_flag: got %b want %b", full, m_full()); end
    checks++; if (fill[FW +: FW] !== 6'd32 || fill[0 +: FW] !== 6'd1) begin
      errors++; $display("FAIL full_fill: got %h want b1=32 b0=1", fill); end
  endtask

  task automatic test_wrap();
    int nxt = 0;
    cycle(0, 0, 0, 0, 1);
    for (int i = 0; i < 48; i++) begin
      cycle(i < 40, DW'(i), (i < 40) ? 3'b100 : 3'b000, (q[2].size() > 0) ? 3'b100 : 3'b000, 0);
      checks++; if (out_valid !== m_ov) begin errors++; $display("FAIL wrap_valid_%0d: got %b want %b", i, out_valid, m_ov); end
      if (m_ov[2]) begin
        checks++; if (out_data[2*DW +: DW] !== DW'(nxt)) begin
          errors++; $display("FAIL wrap_data_%0d: got %0d want %0d", i, out_data[2*DW +: DW], nxt); end
        nxt++;
      end
    end
    checks++; if (nxt != 40 || empty !== 3'b111 || underflow !== 3'b000) begin
      errors++; $display("FAIL wrap_total: got %0d words empty %b uf %b want 40 111 000", nxt, empty, underflow); end
  endtask

  task automatic test_commit_pop();
    logic [DW-1:0] want [6];
    want = '{8'd10, 8'd11, 8'd12, 8'd13, 8'd14, 8'd100};
    cycle(0, 0, 0, 0, 1);
    for (int i = 0; i < 5; i++) cycle(1, DW'(10 + i), 3'b001, 0, 0);
    cycle(1, 8'd100, 3'b001, 0, 0);
    checks++; if (fill[0 +: FW] !== 6'd5) begin errors++; $display("FAIL cp_fill_before: got %0d want 5", fill[0 +: FW]); end
    cycle(0, 0, 0, 3'b001, 0);
    checks++; if (fill[0 +: FW] !== 6'd5 || fill !== m_fill()) begin
      errors++; $display("FAIL cp_fill_same: got %0d want 5", fill[0 +: FW]); end
    for (int k = 0; k < 6; k++) begin
      if (k > 0) cycle(0, 0, 0, 3'b001, 0);
      checks++; if (out_valid[0] !== 1'b1 || out_data[0 +: DW] !== want[k] || out_data !== m_data()) begin
        errors++; $display("FAIL cp_order_%0d: got v%b %0d want v1 %0d", k, out_valid[0], out_data[0 +: DW], want[k]); end
    end
  endtask

  task automatic test_underflow_reset();
    cycle(0, 0, 0, 0, 1);
    cycle(0, 0, 0, 3'b100, 0);
    checks++; if (out_valid[2] !== 1'b0 || underflow !== 3'b100) begin
      errors++; $display("FAIL uf_set: got v%b uf %b want v0 uf 100", out_valid[2], underflow); end
    for (int i = 0; i < 3; i++) cycle(0, 0, 0, 0, 0);
    checks++; if (underflow !== 3'b100 || fill !== '0) begin
      errors++; $display("FAIL uf_sticky: got uf %b fill %h want 100 0", underflow, fill); end
    cycle(1, 8'h77, 3'b111, 0, 0);
    cycle(1, 8'h78, 3'b111, 0, 1);
    checks++; if (fill !== '0 || empty !== 3'b111 || underflow !== 3'b000) begin
      errors++; $display("FAIL midreset: got fill %h empty %b uf %b want 0 111 000", fill, empty, underflow); end
    cycle(0, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0);
    checks++; if (fill !== '0 || empty !== 3'b111) begin
      errors++; $display("FAIL midreset_pending: got fill %h empty %b want 0 111", fill, empty); end
  endtask

  task automatic test_random();
    cycle(0, 0, 0, 0, 1);
    for (int i = 0; i < 600; i++) begin
      cycle(($urandom_range(0, 9) < 8), DW'($urandom), NB'($urandom), NB'($urandom & $urandom),
            ($urandom_range(0, 199) == 0));
      checks++;
      if (obs_ready !== exp_ready || empty !== m_empty() || full !== m_full() || fill !== m_fill() ||
          out_valid !== m_ov || out_data !== m_data() || underflow !== m_uf) begin
        errors++;
        $display("FAIL rand_%0d: got rdy%b e%b f%b fill%h v%b d%h uf%b want rdy%b e%b f%b fill%h v%b d%h uf%b",
                 i, obs_ready, empty, full, fill, out_valid, out_data, underflow,
                 exp_ready, m_empty(), m_full(), m_fill(), m_ov, m_data(), m_uf);
      end
    end
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_data = '0; in_mask = '0; rd_en = '0;
    m_pv = 1'b0; m_pd = '0; m_pm = '0; m_ov = '0; m_uf = '0;
    for (int b = 0; b < NB; b++) m_od[b] = '0;
    test_reset();
    test_single_write();
    test_fill_full();
    test_wrap();
    test_commit_pop();
    test_underflow_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
